// File: rtl/serial_mag_comparator.sv
// Bit-serial WIDTH-bit magnitude comparator: MSB-first, one bit per core cycle, start/done handshake.
// Latency: WIDTH cycles from accepted start to done (SERCMP_EARLY_EXIT_EN: first differing bit position).
// Backpressure: start is ignored while busy; a start in the done cycle is accepted immediately.
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             smaller,
    output logic             greater,
    output logic             equal
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic             decided;
    logic             dec_gt;

    logic bit_a;
    logic bit_b;
    logic bit_diff;
    logic next_decided;
    logic next_gt;
    logic finish;

    // One-bit compare cell on the current MSBs; a decision already made is sticky.
    always_comb begin
        bit_a        = sh_a[WIDTH-1];
        bit_b        = sh_b[WIDTH-1];
        bit_diff     = bit_a ^ bit_b;
        next_decided = decided | bit_diff;
        next_gt      = decided ? dec_gt : bit_a;
`ifdef SERCMP_EARLY_EXIT_EN
        // Stop on the first differing bit; equal operands still walk all bits.
        finish       = (cnt == '0) || (!decided && bit_diff);
`else
        finish       = (cnt == '0);
`endif
    end

    assign busy = (state == RUN);

    // Control FSM, operand shift registers and registered result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sh_a    <= '0;
            sh_b    <= '0;
            cnt     <= '0;
            decided <= 1'b0;
            dec_gt  <= 1'b0;
            done    <= 1'b0;
            smaller <= 1'b0;
            greater <= 1'b0;
            equal   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    sh_a    <= a;
                    sh_b    <= b;
                    cnt     <= CW'(WIDTH - 1);
                    decided <= 1'b0;
                    dec_gt  <= 1'b0;
                    smaller <= 1'b0;
                    greater <= 1'b0;
                    equal   <= 1'b0;
                    state   <= RUN;
                end
            end else begin
                sh_a    <= {sh_a[WIDTH-2:0], 1'b0};
                sh_b    <= {sh_b[WIDTH-2:0], 1'b0};
                cnt     <= cnt - CW'(1);
                decided <= next_decided;
                dec_gt  <= next_gt;
                if (finish) begin
                    greater <= next_decided & next_gt;
                    smaller <= next_decided & ~next_gt;
                    equal   <= ~next_decided;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator: directed cases plus random operands, scoreboard-checked.
// Expected result and done cycle come from plain integer comparison of the operands.
// Outputs are sampled on the falling edge; inputs change 1 ns after the rising edge.
module tb_serial_mag_comparator;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic         smaller;
    logic         greater;
    logic         equal;

    serial_mag_comparator #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .smaller (smaller),
        .greater (greater),
        .equal   (equal)
    );

    always #5 clk = ~clk;

    // Count of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] res;
        int         done_cyc;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         checks = 0;
    int         fails = 0;
    logic       have_last = 1'b0;
    logic [2:0] last_res = 3'b000;
    int         last_done = 0;
    int         busy_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference result as {smaller, greater, equal}.
    function automatic logic [2:0] exp_of(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x < y)      return 3'b100;
        else if (x > y) return 3'b010;
        else            return 3'b001;
    endfunction

    function automatic int lat_of(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERCMP_EARLY_EXIT_EN
        for (int i = W - 1; i >= 0; i--)
            if (x[i] != y[i]) return W - i;
`endif
        return W;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive start with operands; the model accepts it only if the previous compare has completed.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t n;
        a = x;
        b = y;
        start = 1'b1;
        if (cyc >= last_done) begin
            n.res      = exp_of(x, y);
            n.lat      = lat_of(x, y);
            n.done_cyc = cyc + 1 + n.lat;
            last_done  = n.done_cyc;
            exp_q.push_back(n);
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (cyc < last_done && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    // Monitor: pops the scoreboard on every done pulse and checks hold/clear behaviour otherwise.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", 32'({smaller, greater, equal}), 32'(e.res));
                check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                check("busy_cycles", 32'(busy_run), 32'(e.lat));
                check("busy_at_done", 32'(busy), 32'd0);
                have_last = 1'b1;
                last_res  = e.res;
            end
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
            check("cleared_while_busy", 32'({smaller, greater, equal}), 32'd0);
        end else begin
            check("held_result", 32'({smaller, greater, equal}),
                  32'(have_last ? last_res : 3'b000));
        end
    end

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;

        // Reset held for 3 cycles with start toggling: everything stays low.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            start = ~start;
            a = 8'h55;
            b = 8'hAA;
            check("reset_outputs", 32'({busy, done, smaller, greater, equal}), 32'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        last_done = cyc;
        step();

        // Equal operands.
        issue(8'hA5, 8'hA5); step(); start = 1'b0;
        wait_idle(); repeat (2) step();

        // Greater decided on the MSB.
        issue(8'h80, 8'h7F); step(); start = 1'b0;
        wait_idle(); step();

        // Smaller decided on the LSB, then held over idle cycles.
        issue(8'h12, 8'h13); step(); start = 1'b0;
        wait_idle(); repeat (6) step();

        // Start while busy is ignored.
        issue(8'h01, 8'h02); step(); start = 1'b0;
        step(); step();
        issue(8'hFF, 8'h00); step(); start = 1'b0;
        wait_idle(); step();

        // Reset mid-compare aborts with no done pulse.
        issue(8'h01, 8'h02); step(); start = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        exp_q.delete();
        have_last = 1'b0;
        busy_run  = 0;
        #1;
        check("abort_outputs", 32'({busy, done, smaller, greater, equal}), 32'd0);
        step(); step();
        rst_n = 1'b1;
        last_done = cyc;
        step();

        // start held high: second load lands in the done cycle.
        issue(8'h10, 8'h20); step();
        while (cyc < last_done) begin
            issue(8'h10, 8'h20);
            step();
        end
        issue(8'h30, 8'h20); step(); start = 1'b0;
        wait_idle(); step();

        // Extremes.
        issue(8'h00, 8'hFF); step(); start = 1'b0; wait_idle();
        issue(8'hFF, 8'hFF); step(); start = 1'b0; wait_idle();
        issue(8'hFE, 8'hFF); step(); start = 1'b0; wait_idle(); step();

        // Random operands, random gaps (zero gap = back-to-back start in the done cycle),
        // occasional ignored starts mid-compare.
        for (int n = 0; n < 60; n++) begin
            x = W'($urandom);
            case ($urandom_range(0, 2))
                0:       y = W'($urandom);
                1:       y = x;
                default: y = x ^ (W'(1) << $urandom_range(0, W - 1));
            endcase
            issue(x, y); step(); start = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 3)) step();
                if (cyc < last_done) begin
                    issue(W'($urandom), W'($urandom)); step(); start = 1'b0;
                end
            end
            wait_idle();
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
